alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the single-cycle datapath ALU. It executes the full 14-operation MIPS-style operation set on n-bit operands under a Start/Done handshake. Single-cycle operations complete one edge after acceptance; an optional iterative signed/unsigned multiplier produces a 2n-bit product over n cycles. The block sits in the EX stage of the multicycle datapath, and the control FSM waits on Done.

## Interface
- n, 32, operand and result width; ≥ 8, even.
- SHW, $clog2(n), shift-amount width; derived, not overridden.
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request; accepted only when Busy=0.
- ALUCtrl  in  4  operation code, sampled on accept.
- BusA  in  n  operand A; also the shift amount source, BusA[SHW-1:0].
- BusB  in  n  operand B.
- BusW  out  n  result, or low half of the product.
- BusHi  out  n  high half of the product; 0 for non-multiply ops.
- Zero  out  1  1 when the registered result is all zero.
- Overflow  out  1  signed overflow, for ADD/SUB only.
- Busy  out  1  multiply in progress.
- Done  out  1  one-cycle completion pulse.

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, MULT 0101, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110, MULTU 1111.
- Arithmetic wraps modulo 2^n.
- Overflow = (sign A == sign B') && (sign result != sign A), where B' = B for ADD and ~B for SUB. Overflow is 0 for ADDU/SUBU and for all other ops.
- SLT/SLTU: result is 1 or 0, zero-extended; signed or unsigned compare respectively.
- Shifts operate on BusB by BusA[SHW-1:0]. SRA replicates BusB[n-1].
- LUI = BusB << (n/2).
- Undefined codes (incl. MULT/MULTU when compiled out): BusW=0, BusHi=0, Zero=1, Overflow=0; Done still pulses.
- Zero covers BusW only for non-multiply ops, and {BusHi,BusW} for multiply ops.
- FSM states:
  - IDLE: on Start with a non-multiply op, register the results; stay in IDLE.
  - IDLE: on Start with a multiply op, latch operand magnitudes and signs, clear the accumulator, load counter=n, go to MUL.
  - MUL: one shift-add step per edge, counter decrements. When counter reaches 1, write {BusHi,BusW}, negating if MULT and the signs differ, then go to IDLE.
- Start while Busy=1: ignored; no queuing.
- Outputs hold their value until the next completion.

## Timing
- Reset values: BusW=0, BusHi=0, Zero=1, Overflow=0, Busy=0, Done=0; state IDLE; counter 0.
- Non-multiply latency: Start sampled at edge k. Results are valid and Done=1 from edge k until edge k+1. Busy stays 0.
- Multiply latency: accept at edge k sets Busy=1. Results update at edge k+n, where Done=1 and Busy=0 for one cycle.
- Back-to-back: Start may be high while Done=1; the new op is accepted at that edge.
- Start held high continuously: a new op is accepted on every cycle that Busy=0.
- Reset mid-multiply: immediate abort, all reset values restored, partial product discarded.

## Configuration
- ALU_MULT_EN defined: MULT/MULTU are implemented as described; Busy can assert.
- ALU_MULT_EN undefined: 0101/1111 are handled as undefined codes; Busy is tied to 0; the multiplier and its state are absent.

## Structure
- Package alu_pkg holds:
  - the 16 opcode localparams;
  - the FSM state encoding (IDLE, MUL);
  - a function returning the single-cycle result for (op, a, b).
- Sub-module alu_mul_iter is the n-cycle unsigned shift-add core (start, done, 2n-bit product). The top level does sign handling. The sub-module is instantiated only under ALU_MULT_EN.

## Test plan
- Reset asserted mid-multiply at cycle 5 -> all outputs return to reset values at once; the next Start behaves normally.
- ADD 0x7FFFFFFF + 0x00000001 -> BusW=0x80000000, Overflow=1, Zero=0, Done one cycle later. ADDU with the same operands -> Overflow=0.
- SUB 5-5 -> BusW=0, Zero=1. SLT A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0.
- SRA BusB=0x80000000, BusA=4 -> 0xF8000000. SLL BusA=33 (uses 1) -> BusB<<1. LUI BusB=0x1234 -> 0x12340000.
- MULT A=-3, B=7 (ALU_MULT_EN) -> Busy for 32 cycles, then {BusHi,BusW}=0xFFFFFFFF_FFFFFFEB. Start pulsed while Busy is ignored. MULTU 0xFFFFFFFF×2 -> BusHi=1, BusW=0xFFFFFFFE.
- n=8 build, back-to-back AND/OR/XOR with Start held high -> one Done per cycle with correct results. Code 0101 with the macro off -> BusW=0, Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and single-cycle result function for alu_seq.
// alu_op supports operand widths up to ALU_XMAX bits.
package alu_pkg;

  localparam int ALU_XMAX = 64;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_ADDU  = 4'b1000;
  localparam logic [3:0] OP_SUBU  = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1110;
  localparam logic [3:0] OP_MULTU = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // a and b arrive zero-extended from w bits; only the low w bits
  // of the return value are meaningful.
  function automatic logic [ALU_XMAX-1:0] alu_op(
    input logic [3:0]          op,
    input logic [ALU_XMAX-1:0] a,
    input logic [ALU_XMAX-1:0] b,
    input int                  w,
    input int                  shw
  );
    logic [ALU_XMAX-1:0] r;
    logic [ALU_XMAX-1:0] hi_fill;
    logic [ALU_XMAX-1:0] sa;
    logic [ALU_XMAX-1:0] sb;
    logic [5:0]          sh;
    logic                a_neg;
    logic                b_neg;
    r       = '0;
    hi_fill = ~((64'd1 << w) - 64'd1);
    a_neg   = |(a & (64'd1 << (w - 1)));
    b_neg   = |(b & (64'd1 << (w - 1)));
    sa      = a_neg ? (a | hi_fill) : a;
    sb      = b_neg ? (b | hi_fill) : b;
    sh      = a[5:0] & ((6'd1 << shw) - 6'd1);
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD,
      OP_ADDU: r = a + b;
      OP_SUB,
      OP_SUBU: r = a - b;
      OP_SLT:  r[0] = $signed(sa) < $signed(sb);
      OP_SLTU: r[0] = a < b;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = $signed(sb) >>> sh;
      OP_LUI:  r = b << (w / 2);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: n-cycle unsigned shift-add multiplier core.
// Ports: start loads a/b; done flags the final step; product is that step's value.
module alu_mul_iter #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           done,
  output logic [2*n-1:0] product
);

  localparam int CW = $clog2(n + 1);

  logic [2*n-1:0] acc;
  logic [n-1:0]   mcand;
  logic [CW-1:0]  cnt;
  logic [n:0]     sum;

  // acc = {partial high half, multiplier bits not yet consumed}
  assign sum     = {1'b0, acc[2*n-1:n]}
                 + (acc[0] ? {1'b0, mcand} : '0);
  assign product = {sum, acc[n-1:1]};
  assign done    = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (start) begin
      acc   <= {{n{1'b0}}, b};
      mcand <= a;
      cnt   <= CW'(n);
    end else if (cnt != '0) begin
      acc   <= product;
      cnt   <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered 16-op ALU with Start/Done handshake; ALU_MULT_EN adds MULT/MULTU.
// Ports: Clk, Reset, Start, ALUCtrl, BusA, BusB -> BusW, BusHi, Zero, Overflow, Busy, Done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   ALUCtrl,
  input  logic [n-1:0] BusA,
  input  logic [n-1:0] BusB,
  output logic [n-1:0] BusW,
  output logic [n-1:0] BusHi,
  output logic         Zero,
  output logic         Overflow,
  output logic         Busy,
  output logic         Done
);

  localparam int SHW = $clog2(n);

  logic [n-1:0]   res;
  logic           ovf;
  logic           add_ovf;
  logic           sub_ovf;
  logic           accept;
  logic           is_mul;
  logic           mul_fin;
  logic [2*n-1:0] prod;

  assign res = n'(alu_op(ALUCtrl, ALU_XMAX'(BusA),
                         ALU_XMAX'(BusB), n, SHW));

  assign add_ovf = (BusA[n-1] == BusB[n-1])
                && (res[n-1] != BusA[n-1]);
  assign sub_ovf = (BusA[n-1] != BusB[n-1])
                && (res[n-1] != BusA[n-1]);
  assign ovf = (ALUCtrl == OP_ADD) ? add_ovf :
               (ALUCtrl == OP_SUB) ? sub_ovf : 1'b0;

  assign accept = Start && !Busy;

`ifdef ALU_MULT_EN
  state_t         state;
  state_t         state_d;
  logic           sign_a;
  logic           sign_b;
  logic           mul_neg;
  logic           mul_done;
  logic [n-1:0]   mag_a;
  logic [n-1:0]   mag_b;
  logic [2*n-1:0] mag_p;

  assign is_mul = (ALUCtrl == OP_MULT)
               || (ALUCtrl == OP_MULTU);
  assign sign_a = (ALUCtrl == OP_MULT) && BusA[n-1];
  assign sign_b = (ALUCtrl == OP_MULT) && BusB[n-1];
  assign mag_a  = sign_a ? -BusA : BusA;
  assign mag_b  = sign_b ? -BusB : BusB;

  assign Busy    = (state == S_MUL);
  assign mul_fin = Busy && mul_done;
  assign prod    = mul_neg ? -mag_p : mag_p;

  alu_mul_iter #(.n(n)) u_mul (
    .clk     (Clk),
    .rst     (Reset),
    .start   (accept && is_mul),
    .a       (mag_a),
    .b       (mag_b),
    .done    (mul_done),
    .product (mag_p)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (accept && is_mul) state_d = S_MUL;
      S_MUL:  if (mul_done)         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                  mul_neg <= 1'b0;
    else if (accept && is_mul)  mul_neg <= sign_a ^ sign_b;
  end
`else
  assign is_mul  = 1'b0;
  assign mul_fin = 1'b0;
  assign prod    = '0;
  assign Busy    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      BusW     <= '0;
      BusHi    <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept && !is_mul) begin
        BusW     <= res;
        BusHi    <= '0;
        Zero     <= (res == '0);
        Overflow <= ovf;
        Done     <= 1'b1;
      end else if (mul_fin) begin
        BusW     <= prod[n-1:0];
        BusHi    <= prod[2*n-1:n];
        Zero     <= (prod == '0);
        Overflow <= 1'b0;
        Done     <= 1'b1;
      end
    end
  end

endmodule
